rgb_duty_ctrl: RTL
==================

// Module: rgb_duty_ctrl
// PURPOSE
//  Button-driven controller for the RGB LED driver: owns colour selection (H1) and the three duty-cycle
//  registers, steps the selected channel's duty on INC/DEC presses and generates the three PWM outputs.
//  Sits between the debounced button inputs / prescaler CE and the LED pins.
//  Sequences channel choice and duty updates so that a PWM period never sees a mid-period duty change.
// PARAMETERS
//  W           8    duty and PWM counter width; period = 2**W CLK cycles
//  STEP        16   duty increment/decrement per step
//  INIT_DUTY   0    reset value of all three duty registers (< 2**W)
//  HOLD_TICKS  50   CE_IN ticks a button is held before auto-repeat starts (AUTOREPEAT_EN only)
//  RPT_TICKS   10   CE_IN ticks between auto-repeat steps (AUTOREPEAT_EN only)
// PORTS
//  CLK     in   1   system clock, single clock domain
//  CLR     in   1   synchronous, active-high reset
//  CE_IN   in   1   one-cycle tick from prescaler; all button sampling happens only on CE_IN cycles
//  SEL     in   1   colour select button (debounced, level)
//  INC     in   1   duty up button (debounced, level)
//  DEC     in   1   duty down button (debounced, level)
//  H1      out  2   selected channel: 0=R, 1=G, 2=B
//  DUTY_R  out  W   red duty register (current, not shadow)
//  DUTY_G  out  W   green duty register
//  DUTY_B  out  W   blue duty register
//  PWM_R   out  1   red PWM output
//  PWM_G   out  1   green PWM output
//  PWM_B   out  1   blue PWM output
// BEHAVIOUR
//  Reset (CLR=1 at posedge): H1=0, DUTY_*=INIT_DUTY, shadows=INIT_DUTY, PWM counter=0, PWM_*=0,
//   FSM=IDLE, button history=0, tick counter=0. CLR overrides every other input, including mid-repeat.
//  Press detection: on CE_IN cycles, press = button sampled 1 now and 0 at previous CE_IN sample.
//  Selection: SEL press -> H1 advances 0->1->2->0; H1 never takes value 3. Update visible 1 CLK later.
//  Priority within one CE_IN sample: SEL press wins; INC/DEC ignored that sample. INC and DEC both
//   high -> no step, FSM returns to IDLE.
//  Step: INC -> DUTY[H1] = min(DUTY[H1]+STEP, 2**W-1); DEC -> DUTY[H1] = max(DUTY[H1]-STEP, 0).
//   Compute in W+1 bits; saturate, never wrap. DUTY_* reflect step 1 CLK after the CE_IN cycle.
//  FSM states: IDLE (no button), PRESS (step applied on press edge), HOLD (counting CE ticks while held),
//   REPEAT (periodic steps). Release of the active button in any state -> IDLE on that CE_IN sample.
//   IDLE->PRESS on INC/DEC press; PRESS->HOLD next CE tick if still held; HOLD/REPEAT per macro below.
//  PWM: free-running W-bit counter, +1 every CLK, wraps 2**W-1 -> 0.
//   PWM_x registered: PWM_x = (cnt < shadow_x). Duty 0 -> constant 0; duty 2**W-1 -> high 2**W-1 of 2**W.
//   Shadow_x <= DUTY_x only on the cycle cnt==2**W-1, so new duty applies from next period start.
//   Duty changes coinciding with the wrap cycle are captured at the following wrap (one period later).
// CONFIGURATION
//  RGB_DUTY_AUTOREPEAT_EN defined: HOLD counts CE ticks; after HOLD_TICKS ticks held -> REPEAT, one step
//   immediately then every RPT_TICKS ticks until release; saturation still applies each step.
//  Not defined: one step per press only; FSM stays in HOLD until release, REPEAT unreachable,
//   HOLD_TICKS/RPT_TICKS unused.
// TESTING
//  CLR 1 cycle, INIT_DUTY=0 -> H1=0, DUTY_*=0, PWM_*=0 for a full 256-cycle period.
//  3 SEL presses (each spanning CE ticks) -> H1 sequence 1,2,0; never 3.
//  H1=1, 20 INC presses, STEP=16 -> DUTY_G=16,32,...,240,255,255..; DUTY_R/B unchanged; 17 DEC -> 0, stays 0.
//  DUTY_R=64 set mid-period -> PWM_R unchanged until wrap, then high exactly 64 of next 256 cycles.
//  SEL and INC pressed same CE sample -> H1 advances, no duty change; INC+DEC together -> no change.
//  With RGB_DUTY_AUTOREPEAT_EN, INC held 80 ticks (HOLD=50,RPT=10) -> steps at press, tick 50, 60, 70, 80;
//   CLR asserted at tick 65 -> all outputs at reset values, no further steps.

Source files
------------

// File: rtl/rgb_duty_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rgb_duty_ctrl_if
// Description : Button/CE inputs and LED-side outputs of the RGB duty
//               controller, bundled as one interface.
//               master : button/prescaler side (drives CE_IN, SEL, INC, DEC)
//               slave  : controller side (drives H1, DUTY_*, PWM_*)
// Ports       : CE_IN, SEL, INC, DEC (1b each) ; H1 (2b) ;
//               DUTY_R/G/B (W bits) ; PWM_R/G/B (1b each)
// Revision    : 1.0 - initial release
// ============================================================================
interface rgb_duty_ctrl_if #(
    parameter int W = 8
);
    logic           CE_IN;
    logic           SEL;
    logic           INC;
    logic           DEC;
    logic [1:0]     H1;
    logic [W-1:0]   DUTY_R;
    logic [W-1:0]   DUTY_G;
    logic [W-1:0]   DUTY_B;
    logic           PWM_R;
    logic           PWM_G;
    logic           PWM_B;

    modport master (
        output CE_IN, SEL, INC, DEC,
        input  H1, DUTY_R, DUTY_G, DUTY_B, PWM_R, PWM_G, PWM_B
    );

    modport slave (
        input  CE_IN, SEL, INC, DEC,
        output H1, DUTY_R, DUTY_G, DUTY_B, PWM_R, PWM_G, PWM_B
    );
endinterface
`default_nettype wire

// File: rtl/rgb_duty_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rgb_duty_ctrl
// Description : Button-driven RGB duty controller. Selects a colour channel
//               with SEL, steps its duty with INC/DEC (saturating), and
//               generates three PWM outputs whose duty only changes at a
//               period boundary (shadow registers loaded on counter wrap).
// Ports       : CLK  - system clock
//               CLR  - synchronous active-high reset
//               bus  - rgb_duty_ctrl_if.slave (CE_IN/SEL/INC/DEC in,
//                      H1/DUTY_*/PWM_* out)
// Options     : RGB_DUTY_AUTOREPEAT_EN - when defined, a held INC/DEC
//               auto-repeats after HOLD_TICKS CE ticks, then every
//               RPT_TICKS CE ticks. Undefined: one step per press.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_duty_ctrl #(
    parameter int W          = 8,
    parameter int STEP       = 16,
    parameter int INIT_DUTY  = 0,
    parameter int HOLD_TICKS = 50,
    parameter int RPT_TICKS  = 10
) (
    input  wire logic       CLK,
    input  wire logic       CLR,
    rgb_duty_ctrl_if.slave  bus
);

    localparam logic [1:0]   c_IDLE   = 2'd0;
    localparam logic [1:0]   c_PRESS  = 2'd1;
    localparam logic [1:0]   c_HOLD   = 2'd2;
    localparam logic [1:0]   c_REPEAT = 2'd3;

    localparam logic [W-1:0] c_INIT   = INIT_DUTY[W-1:0];
    localparam logic [W-1:0] c_MAX    = {W{1'b1}};
    localparam logic [W:0]   c_STEP   = STEP[W:0];

    // Elaboration-time sanity checks on the configuration.
    if (HOLD_TICKS < 2 || RPT_TICKS < 1 || INIT_DUTY >= (2 ** W) ||
        STEP < 1 || STEP >= (2 ** W)) begin : g_bad_params
        $error("rgb_duty_ctrl: illegal parameter combination");
    end

`ifdef RGB_DUTY_AUTOREPEAT_EN
    localparam int c_TMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_HOLD_N = HOLD_TICKS[c_TW-1:0];
    localparam logic [c_TW-1:0] c_RPT_N  = RPT_TICKS[c_TW-1:0];

    logic [c_TW-1:0] r_tick_q, w_tick_d;
    logic [c_TW-1:0] w_tick_inc;
`endif

    logic [1:0]   r_h1_q,    w_h1_d;
    logic [1:0]   r_state_q, w_state_d;
    logic         r_dir_q,   w_dir_d;     // 1 = INC is the active button
    logic [2:0]   r_btn_q,   w_btn_d;     // {SEL, INC, DEC} at previous CE sample
    logic [W-1:0] r_duty_q   [3];
    logic [W-1:0] w_duty_d   [3];
    logic [W-1:0] r_shadow_q [3];
    logic [W-1:0] w_shadow_d [3];
    logic [W-1:0] r_cnt_q,   w_cnt_d;
    logic [2:0]   r_pwm_q,   w_pwm_d;

    logic [2:0]   w_btn;
    logic [2:0]   w_press;
    logic         w_held;
    logic         w_step;
    logic         w_step_up;
    logic [W-1:0] w_cur;
    logic [W:0]   w_sum;
    logic [W:0]   w_dif;
    logic [W-1:0] w_next;
    logic         w_wrap;

    assign w_btn   = {bus.SEL, bus.INC, bus.DEC};
    assign w_press = w_btn & ~r_btn_q;
    assign w_held  = r_dir_q ? bus.INC : bus.DEC;

`ifdef RGB_DUTY_AUTOREPEAT_EN
    assign w_tick_inc = r_tick_q + 1'b1;
`endif

    // ------------------------------------------------------------------
    // Selection + button FSM; everything advances on CE_IN cycles only.
    // ------------------------------------------------------------------
    always_comb begin
        w_h1_d    = r_h1_q;
        w_state_d = r_state_q;
        w_dir_d   = r_dir_q;
        w_btn_d   = r_btn_q;
        w_step    = 1'b0;
        w_step_up = r_dir_q;
`ifdef RGB_DUTY_AUTOREPEAT_EN
        w_tick_d  = r_tick_q;
`endif
        if (bus.CE_IN) begin
            w_btn_d = w_btn;
            if (w_press[2]) begin
                // SEL press suppresses INC/DEC on the same sample; a button
                // still held afterwards needs a fresh press to step again.
                w_h1_d    = (r_h1_q == 2'd2) ? 2'd0 : r_h1_q + 2'd1;
                w_state_d = c_IDLE;
            end else if (bus.INC && bus.DEC) begin
                w_state_d = c_IDLE;
            end else begin
                case (r_state_q)
                    c_IDLE: begin
                        if (w_press[1]) begin
                            w_state_d = c_PRESS;
                            w_dir_d   = 1'b1;
                            w_step    = 1'b1;
                            w_step_up = 1'b1;
                        end else if (w_press[0]) begin
                            w_state_d = c_PRESS;
                            w_dir_d   = 1'b0;
                            w_step    = 1'b1;
                            w_step_up = 1'b0;
                        end
                    end
                    c_PRESS: begin
                        if (w_held) begin
                            w_state_d = c_HOLD;
`ifdef RGB_DUTY_AUTOREPEAT_EN
                            // Press sample was tick 0; this is tick 1.
                            w_tick_d  = {{(c_TW-1){1'b0}}, 1'b1};
`endif
                        end else begin
                            w_state_d = c_IDLE;
                        end
                    end
                    c_HOLD: begin
                        if (!w_held) begin
                            w_state_d = c_IDLE;
                        end else begin
`ifdef RGB_DUTY_AUTOREPEAT_EN
                            if (w_tick_inc == c_HOLD_N) begin
                                w_state_d = c_REPEAT;
                                w_step    = 1'b1;
                                w_tick_d  = '0;
                            end else begin
                                w_tick_d  = w_tick_inc;
                            end
`endif
                        end
                    end
                    c_REPEAT: begin
                        if (!w_held) begin
                            w_state_d = c_IDLE;
                        end else begin
`ifdef RGB_DUTY_AUTOREPEAT_EN
                            if (w_tick_inc == c_RPT_N) begin
                                w_step   = 1'b1;
                                w_tick_d = '0;
                            end else begin
                                w_tick_d = w_tick_inc;
                            end
`endif
                        end
                    end
                    default: w_state_d = c_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating step on the selected channel (one extra bit for carry /
    // borrow detection).
    // ------------------------------------------------------------------
    always_comb begin
        case (r_h1_q)
            2'd1:    w_cur = r_duty_q[1];
            2'd2:    w_cur = r_duty_q[2];
            default: w_cur = r_duty_q[0];
        endcase
        w_sum = {1'b0, w_cur} + c_STEP;
        w_dif = {1'b0, w_cur} - c_STEP;
        if (w_step_up) begin
            w_next = w_sum[W] ? c_MAX : w_sum[W-1:0];
        end else begin
            w_next = w_dif[W] ? '0 : w_dif[W-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_duty_d[i] = r_duty_q[i];
            if (w_step && (r_h1_q == 2'(i))) begin
                w_duty_d[i] = w_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM: shadows load on the last count of a period so a period always
    // runs on one duty value.
    // ------------------------------------------------------------------
    assign w_wrap  = (r_cnt_q == c_MAX);
    assign w_cnt_d = r_cnt_q + 1'b1;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_shadow_d[i] = w_wrap ? r_duty_q[i] : r_shadow_q[i];
            w_pwm_d[i]    = (r_cnt_q < r_shadow_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_h1_q    <= 2'd0;
            r_state_q <= c_IDLE;
            r_dir_q   <= 1'b0;
            r_btn_q   <= 3'b000;
            r_cnt_q   <= '0;
            r_pwm_q   <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_duty_q[i]   <= c_INIT;
                r_shadow_q[i] <= c_INIT;
            end
`ifdef RGB_DUTY_AUTOREPEAT_EN
            r_tick_q  <= '0;
`endif
        end else begin
            r_h1_q    <= w_h1_d;
            r_state_q <= w_state_d;
            r_dir_q   <= w_dir_d;
            r_btn_q   <= w_btn_d;
            r_cnt_q   <= w_cnt_d;
            r_pwm_q   <= w_pwm_d;
            for (int i = 0; i < 3; i++) begin
                r_duty_q[i]   <= w_duty_d[i];
                r_shadow_q[i] <= w_shadow_d[i];
            end
`ifdef RGB_DUTY_AUTOREPEAT_EN
            r_tick_q  <= w_tick_d;
`endif
        end
    end

    assign bus.H1     = r_h1_q;
    assign bus.DUTY_R = r_duty_q[0];
    assign bus.DUTY_G = r_duty_q[1];
    assign bus.DUTY_B = r_duty_q[2];
    assign bus.PWM_R  = r_pwm_q[0];
    assign bus.PWM_G  = r_pwm_q[1];
    assign bus.PWM_B  = r_pwm_q[2];

endmodule
`default_nettype wire
